// File: rtl/fetch_branch_predictor_if.sv
// Fetch-side prediction bus and EX-side resolve/update bus for fetch_branch_predictor.
interface fetch_branch_predictor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned GHR_W  = 4
);
  logic              fetch_en;
  logic [ADDR_W-1:0] pc_if;
  logic [ADDR_W-1:0] next_pc;
  logic              pred_taken;
  logic [GHR_W-1:0]  pred_ghr;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic [GHR_W-1:0]  upd_ghr;

  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispred;

  modport master (
    output fetch_en, pc_if, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, upd_ghr,
    input  next_pc, pred_taken, pred_ghr, mispredict, redirect_pc,
           stat_branches, stat_mispred
  );

  modport slave (
    input  fetch_en, pc_if, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, upd_ghr,
    output next_pc, pred_taken, pred_ghr, mispredict, redirect_pc,
           stat_branches, stat_mispred
  );
endinterface

// File: rtl/fetch_branch_predictor.sv
// IF-stage next-PC predictor: 2-bit counter BHT (bimodal or gshare), tagged direct-mapped BTB,
// global history with mispredict repair, and resolved-branch statistics.
module fetch_branch_predictor #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned BHT_IDX  = 6,
  parameter int unsigned BTB_IDX  = 4,
  parameter int unsigned GHR_W    = 4,
  parameter bit          GSHARE   = 1'b1,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input logic                     clk,
  input logic                     rst,
  fetch_branch_predictor_if.slave bus
);
  localparam int unsigned BHT_N = 1 << BHT_IDX;
  localparam int unsigned BTB_N = 1 << BTB_IDX;
  localparam int unsigned TAG_W = ADDR_W - BTB_IDX - 2;

  logic              btb_valid [BTB_N];
  logic [TAG_W-1:0]  btb_tag   [BTB_N];
  logic [ADDR_W-1:0] btb_tgt   [BTB_N];
  logic [1:0]        cnt       [BHT_N];
  logic [GHR_W-1:0]  ghr;
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispred;

  logic [BTB_IDX-1:0] look_btb_idx;
  logic [TAG_W-1:0]   look_tag;
  logic [BHT_IDX-1:0] look_bht_idx;
  logic [BTB_IDX-1:0] upd_btb_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic [BHT_IDX-1:0] upd_bht_idx;
  logic               btb_hit;
  logic               pred_taken;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               mispredict;

  // Index/tag extraction and zero-latency lookup; bimodal mode leaves history out of the index.
  always_comb begin
    look_btb_idx = bus.pc_if[BTB_IDX+1:2];
    look_tag     = bus.pc_if[ADDR_W-1:BTB_IDX+2];
    look_bht_idx = bus.pc_if[BHT_IDX+1:2] ^ (GSHARE ? BHT_IDX'(ghr) : BHT_IDX'(0));
    upd_btb_idx  = bus.upd_pc[BTB_IDX+1:2];
    upd_tag      = bus.upd_pc[ADDR_W-1:BTB_IDX+2];
    upd_bht_idx  = bus.upd_pc[BHT_IDX+1:2] ^ (GSHARE ? BHT_IDX'(bus.upd_ghr) : BHT_IDX'(0));
    btb_hit      = btb_valid[look_btb_idx] && (btb_tag[look_btb_idx] == look_tag);
    pred_taken   = btb_hit && cnt[look_bht_idx][1];
    redirect_pc  = bus.upd_taken ? bus.upd_target : bus.upd_pc + ADDR_W'(4);
    mispredict   = bus.upd_valid &&
                   ((bus.upd_taken != bus.upd_pred_taken) || (bus.upd_pred_target != redirect_pc));
  end

  assign bus.pred_taken    = pred_taken;
  assign bus.next_pc       = pred_taken ? btb_tgt[look_btb_idx] : bus.pc_if + ADDR_W'(4);
  assign bus.pred_ghr      = ghr;
  assign bus.mispredict    = mispredict;
  assign bus.redirect_pc   = redirect_pc;
  assign bus.stat_branches = stat_branches;
  assign bus.stat_mispred  = stat_mispred;

  // Resettable state: valid bits, counters, history and statistics.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
      for (int i = 0; i < BHT_N; i++) cnt[i] <= CNT_INIT;
      ghr           <= '0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (bus.upd_valid) begin
        if (bus.upd_taken) begin
          btb_valid[upd_btb_idx] <= 1'b1;
          if (cnt[upd_bht_idx] != 2'b11) cnt[upd_bht_idx] <= cnt[upd_bht_idx] + 2'd1;
        end else if (cnt[upd_bht_idx] != 2'b00) begin
          cnt[upd_bht_idx] <= cnt[upd_bht_idx] - 2'd1;
        end
      end
      // Repair from the resolved branch's snapshot beats the speculative shift.
      if (mispredict)
        ghr <= GHR_W'({bus.upd_ghr, bus.upd_taken});
      else if (bus.fetch_en && btb_hit)
        ghr <= GHR_W'({ghr, pred_taken});
      if (bus.upd_valid && stat_branches != 32'hFFFF_FFFF)
        stat_branches <= stat_branches + 32'd1;
      if (mispredict && stat_mispred != 32'hFFFF_FFFF)
        stat_mispred <= stat_mispred + 32'd1;
    end
  end

  // Tag/target payload needs no reset; the valid bit guards it.
  always_ff @(posedge clk) begin
    if (rst && bus.upd_valid && bus.upd_taken) begin
      btb_tag[upd_btb_idx] <= upd_tag;
      btb_tgt[upd_btb_idx] <= bus.upd_target;
    end
  end
endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Directed bench: bimodal instance for training/alias/reset, gshare instance for history repair.
module tb_fetch_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_branch_predictor_if #(.ADDR_W(32), .GHR_W(4)) a ();
  fetch_branch_predictor_if #(.ADDR_W(32), .GHR_W(4)) b ();

  fetch_branch_predictor #(.ADDR_W(32), .BHT_IDX(6), .BTB_IDX(4), .GHR_W(4),
                           .GSHARE(1'b0), .CNT_INIT(2'b01))
    u_bim (.clk(clk), .rst(rst), .bus(a.slave));

  fetch_branch_predictor #(.ADDR_W(32), .BHT_IDX(6), .BTB_IDX(4), .GHR_W(4),
                           .GSHARE(1'b1), .CNT_INIT(2'b01))
    u_gs (.clk(clk), .rst(rst), .bus(b.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic upd_a(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt, input logic [3:0] gh);
    a.upd_valid = 1'b1; a.upd_pc = pc; a.upd_taken = tk; a.upd_target = tgt;
    a.upd_pred_taken = ptk; a.upd_pred_target = ptgt; a.upd_ghr = gh;
  endtask

  task automatic upd_b(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt, input logic [3:0] gh);
    b.upd_valid = 1'b1; b.upd_pc = pc; b.upd_taken = tk; b.upd_target = tgt;
    b.upd_pred_taken = ptk; b.upd_pred_target = ptgt; b.upd_ghr = gh;
  endtask

  task automatic clr_a();
    a.upd_valid = 1'b0; a.upd_pc = '0; a.upd_taken = 1'b0; a.upd_target = '0;
    a.upd_pred_taken = 1'b0; a.upd_pred_target = '0; a.upd_ghr = '0;
  endtask

  task automatic clr_b();
    b.upd_valid = 1'b0; b.upd_pc = '0; b.upd_taken = 1'b0; b.upd_target = '0;
    b.upd_pred_taken = 1'b0; b.upd_pred_target = '0; b.upd_ghr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    a.fetch_en = 1'b0; a.pc_if = '0; clr_a();
    b.fetch_en = 1'b0; b.pc_if = '0; clr_b();
    tick(); tick();
    rst = 1'b1;

    // Post-reset lookup and PC wrap
    a.pc_if = 32'h40; #1;
    chk("rst_pred", 32'(a.pred_taken), 32'd0);
    chk("rst_next", a.next_pc, 32'h44);
    chk("rst_ghr", 32'(a.pred_ghr), 32'd0);
    chk("rst_br", a.stat_branches, 32'd0);
    chk("rst_mp", a.stat_mispred, 32'd0);
    a.pc_if = 32'hFFFF_FFFC; #1;
    chk("wrap_next", a.next_pc, 32'h0);

    // Two taken resolves of 0x100 predicted not-taken
    upd_a(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 4'h0); #1;
    chk("tk1_mp", 32'(a.mispredict), 32'd1);
    chk("tk1_redir", a.redirect_pc, 32'h200);
    tick(); #1;
    chk("tk2_mp", 32'(a.mispredict), 32'd1);
    chk("tk2_redir", a.redirect_pc, 32'h200);
    tick(); clr_a(); a.pc_if = 32'h100; #1;
    chk("tk_pred", 32'(a.pred_taken), 32'd1);
    chk("tk_next", a.next_pc, 32'h200);
    chk("tk_br", a.stat_branches, 32'd2);
    chk("tk_mp", a.stat_mispred, 32'd2);
    chk("tk_ghr", 32'(a.pred_ghr), 32'd1);

    // Two not-taken resolves predicted taken: counter 11 -> 01
    upd_a(32'h100, 1'b0, 32'h200, 1'b1, 32'h200, 4'h0); #1;
    chk("nt_mp", 32'(a.mispredict), 32'd1);
    chk("nt_redir", a.redirect_pc, 32'h104);
    tick(); tick(); clr_a(); #1;
    chk("nt_pred", 32'(a.pred_taken), 32'd0);
    chk("nt_next", a.next_pc, 32'h104);
    chk("nt_mpcnt", a.stat_mispred, 32'd4);

    // Correctly predicted not-taken: no mispredict, counter saturates at 00
    upd_a(32'h100, 1'b0, 32'h200, 1'b0, 32'h104, 4'h0); #1;
    chk("ok_mp", 32'(a.mispredict), 32'd0);
    tick(); tick(); clr_a(); #1;
    chk("sat0_pred", 32'(a.pred_taken), 32'd0);
    chk("sat0_br", a.stat_branches, 32'd6);
    chk("sat0_mp", a.stat_mispred, 32'd4);

    // Taken resolves while looking up the same PC: lookup sees pre-update counter
    upd_a(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 4'h0); #1;
    chk("same_pred0", 32'(a.pred_taken), 32'd0);
    tick(); #1;
    chk("same_pred1", 32'(a.pred_taken), 32'd0);
    tick(); clr_a(); #1;
    chk("same_pred2", 32'(a.pred_taken), 32'd1);
    chk("same_next2", a.next_pc, 32'h200);
    chk("same_br", a.stat_branches, 32'd8);
    chk("same_mp", a.stat_mispred, 32'd6);
    chk("same_ghr", 32'(a.pred_ghr), 32'd1);

    // BTB alias: 0x500 evicts 0x100 in entry 0
    upd_a(32'h500, 1'b1, 32'h600, 1'b0, 32'h504, 4'h0);
    tick(); clr_a(); a.pc_if = 32'h100; #1;
    chk("alias_old_pred", 32'(a.pred_taken), 32'd0);
    chk("alias_old_next", a.next_pc, 32'h104);
    a.pc_if = 32'h500; #1;
    chk("alias_new_next", a.next_pc, 32'h600);

    // One-edge reset with an update present: update dropped, all state cleared
    upd_a(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 4'h0);
    rst = 1'b0;
    tick(); rst = 1'b1; clr_a(); a.pc_if = 32'h500; #1;
    chk("mrst_pred", 32'(a.pred_taken), 32'd0);
    chk("mrst_next", a.next_pc, 32'h504);
    chk("mrst_br", a.stat_branches, 32'd0);
    chk("mrst_mp", a.stat_mispred, 32'd0);
    chk("mrst_ghr", 32'(a.pred_ghr), 32'd0);
    a.pc_if = 32'h100; #1;
    chk("mrst_drop", a.next_pc, 32'h104);

    // Counter back at 01: NT then T leaves it at 01 (not taken)
    upd_a(32'h500, 1'b0, 32'h600, 1'b0, 32'h504, 4'h0); tick();
    upd_a(32'h500, 1'b1, 32'h600, 1'b0, 32'h504, 4'h0); tick();
    clr_a(); a.pc_if = 32'h500; #1;
    chk("init_pred", 32'(a.pred_taken), 32'd0);
    chk("init_next", a.next_pc, 32'h504);
    chk("init_br", a.stat_branches, 32'd2);
    chk("init_mp", a.stat_mispred, 32'd1);
    upd_a(32'h500, 1'b1, 32'h600, 1'b0, 32'h504, 4'h0); tick();
    clr_a(); #1;
    chk("init_pred2", 32'(a.pred_taken), 32'd1);
    chk("init_next2", a.next_pc, 32'h600);

    // Gshare: train 0x100 with history 0, no mispredicts
    upd_b(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 4'h0); #1;
    chk("gs_ok_mp", 32'(b.mispredict), 32'd0);
    tick(); tick(); clr_b();
    b.pc_if = 32'h100; b.fetch_en = 1'b1;
    upd_b(32'h300, 1'b0, 32'h400, 1'b1, 32'h400, 4'b0011); #1;
    chk("gs_pred", 32'(b.pred_taken), 32'd1);
    chk("gs_next", b.next_pc, 32'h200);
    chk("gs_mp", 32'(b.mispredict), 32'd1);
    chk("gs_redir", b.redirect_pc, 32'h304);
    tick(); clr_b(); #1;
    chk("gs_repair", 32'(b.pred_ghr), 32'b0110);
    chk("gs_idx_pred", 32'(b.pred_taken), 32'd0);
    chk("gs_idx_next", b.next_pc, 32'h104);
    tick(); b.fetch_en = 1'b0; #1;
    chk("gs_shift", 32'(b.pred_ghr), 32'b1100);
    tick(); #1;
    chk("gs_hold_en", 32'(b.pred_ghr), 32'b1100);
    b.fetch_en = 1'b1; b.pc_if = 32'h40;
    tick(); #1;
    chk("gs_hold_miss", 32'(b.pred_ghr), 32'b1100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_branch_predictor.md
Name: fetch_branch_predictor

Overview:
- Parametrised successor to the fetch-stage prediction path: one block that combines a BHT of 2-bit saturating counters, a tagged direct-mapped BTB and an optional global history register (gshare mode).
- Produces the next fetch PC every cycle and takes resolved-branch updates from EX.
- Detects mispredictions itself and supplies the redirect PC plus a GHR repair snapshot.
- Sits between the PC register and the PC mux in IF. It replaces the separate BHT/BTB/T_NT wiring.

Parameters:
- ADDR_W, 32, PC width.
- BHT_IDX, 6, log2 of BHT entries (64).
- BTB_IDX, 4, log2 of BTB entries (16).
- GHR_W, 4, global history bits; must satisfy 1 <= GHR_W <= BHT_IDX.
- GSHARE, 1, 1 = BHT index XOR GHR; 0 = bimodal (GHR still maintained but not used for indexing).
- CNT_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- fetch_en  in  1  PC advances this cycle (PCWrite); gates speculative GHR update.
- pc_if  in  ADDR_W  current fetch PC.
- next_pc  out  ADDR_W  predicted next fetch PC (combinational).
- pred_taken  out  1  prediction for pc_if (combinational).
- pred_ghr  out  GHR_W  GHR value used for this lookup; carried down the pipeline.
- upd_valid  in  1  a branch resolved in EX this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual target.
- upd_pred_taken  in  1  prediction that was made for that branch.
- upd_pred_target  in  ADDR_W  next_pc that was predicted for that branch.
- upd_ghr  in  GHR_W  pred_ghr snapshot that was taken for that branch.
- mispredict  out  1  redirect required (combinational from upd_*).
- redirect_pc  out  ADDR_W  correct next PC: upd_taken ? upd_target : upd_pc+4.
- stat_branches  out  32  resolved-branch count.
- stat_mispred  out  32  misprediction count.

Behaviour:
- Lookup (combinational, zero latency):
  - BTB index = pc_if[BTB_IDX+1:2]; tag = pc_if[ADDR_W-1:BTB_IDX+2].
  - btb_hit = valid & tag match.
  - BHT index = pc_if[BHT_IDX+1:2] XOR (GSHARE ? zero-extended GHR : 0).
  - pred_taken = btb_hit & cnt[1].
  - next_pc = pred_taken ? btb_target : pc_if+4. The addition wraps modulo 2^ADDR_W.
- Resolve: mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_pred_target != redirect_pc)).
- Update (next edge, when upd_valid):
  - BHT counter at index(upd_pc, upd_ghr) increments if taken, decrements if not.
  - Counters saturate at 2'b11 and 2'b00.
  - If upd_taken, the BTB entry for upd_pc is written: valid=1, tag, target. A tag mismatch overwrites the old entry.
  - Not-taken never allocates or invalidates a BTB entry.
- GHR, in priority order:
  - mispredict: GHR <= {upd_ghr[GHR_W-2:0], upd_taken}. This repair wins over any speculative shift in the same cycle.
  - else fetch_en & btb_hit: GHR <= {GHR[GHR_W-2:0], pred_taken}.
  - else GHR holds.
  - For GHR_W=1, the shift result is just the new bit.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update contents; the write takes effect at the edge.
- Statistics: on upd_valid, stat_branches += 1; on mispredict, stat_mispred += 1. Both saturate at 32'hFFFFFFFF and never wrap.
- Reset (rst=0 at an edge), applied to all state regardless of other inputs:
  - all BTB valid bits = 0; all counters = CNT_INIT; GHR = 0; stats = 0.
  - Upd_* inputs in that cycle are ignored.
- Outputs after reset: pred_taken=0, next_pc=pc_if+4, pred_ghr=0, stats=0.
- Reset mid-operation discards all history. In-flight upd_* arriving after reset are still applied normally.
- No internal pipeline: one update accepted per cycle, no backpressure.

Test Plan:
- Reset, then pc_if=0x40 -> pred_taken=0, next_pc=0x44, pred_ghr=0. Set pc_if=0xFFFFFFFC -> next_pc=0x0.
- Two taken updates for upd_pc=0x100, upd_target=0x200, upd_pred_taken=0, upd_pred_target=0x104, GSHARE=0 -> mispredict=1 and redirect_pc=0x200 each cycle. Then pc_if=0x100 -> pred_taken=1, next_pc=0x200; stat_branches=2, stat_mispred=2.
- Drive pc_if=0x100 twice, then resolve not-taken twice -> counter reaches 2'b01, pred_taken=0 on the next lookup, next_pc=0x104. Further not-taken updates keep the counter at 2'b00.
- BTB alias: PC 0x100 trained taken (target 0x200), then 0x500 (same index, BTB_IDX=4) taken to 0x600 -> lookup of 0x100 misses (next_pc=0x104); lookup of 0x500 gives 0x600.
- GSHARE=1, fetch_en=1, btb_hit with pred_taken=1 while a mispredict arrives with upd_ghr=4'b0011, upd_taken=0 -> GHR becomes 4'b0110, not the speculative shift.
- Assert rst=0 for one edge mid-stream with upd_valid=1 -> update ignored; all lookups miss, counters=CNT_INIT, stats=0.
